// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch stage and the decode control unit.
//   - opcode constants (Instr[31:26])
//   - NOP_INSTR, the bubble word loaded into IF/ID on flush
//   - PC_WIDTH_DEF, the default PC/address width
//   - fetch FSM state encoding
package mips_pkg;

  localparam int PC_WIDTH_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_TIPOR = 6'h00;  // R-type, decoded by Funct
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : capture instr_i / pcp4_i and mark the entry valid
//   flush_i      : replace the entry with a NOP bubble (pcp4 holds)
//   instr_i/o    : instruction word
//   pcp4_i/o     : PC+4 of that instruction
//   valid_o      : entry holds a real fetched instruction
// Neither load nor flush means hold. Flush has priority over load.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                flush_i,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] pcp4_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pcp4_o,
  output logic                valid_o
);

  logic [31:0]         instr_q;
  logic [PC_WIDTH-1:0] pcp4_q;
  logic                valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pcp4_q  <= pcp4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pcp4_o  = pcp4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage. Owns the PC, drives the
// instruction-memory address, holds IF/ID and forms branch/jump targets
// from the instruction currently in IF/ID.
//   clk, reset          : clock, synchronous active-high reset
//   Stall               : hold PC and IF/ID
//   BranchTaken, Jump   : redirect from ID (Jump target wins if both)
//   Halt                : stop fetching until reset
//   ImemAddr, ImemData  : word address / async-read instruction word
//   PC                  : current fetch PC
//   Instr, IdPCPlus4    : IF/ID contents
//   Valid               : IF/ID holds a real instruction
//   Halted              : fetch permanently stopped
// Optional feature, macro IF_STEP_EN: adds StepMode/StepPulse. In step
// mode, advances and redirects only happen on StepPulse cycles; other
// cycles behave like Stall. Halt and reset are unaffected.
module if_stage
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH        = PC_WIDTH_DEF,
  parameter int                  IMEM_ADDR_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Stall,
  input  logic                       BranchTaken,
  input  logic                       Jump,
  input  logic                       Halt,
`ifdef IF_STEP_EN
  input  logic                       StepMode,
  input  logic                       StepPulse,
`endif
  output logic [IMEM_ADDR_WIDTH-1:0] ImemAddr,
  input  logic [31:0]                ImemData,
  output logic [PC_WIDTH-1:0]        PC,
  output logic [31:0]                Instr,
  output logic [PC_WIDTH-1:0]        IdPCPlus4,
  output logic                       Valid,
  output logic                       Halted
);

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                halted_q;
  logic                load, flush;
  logic                step_blk, redirect, hold;
  logic [PC_WIDTH-1:0] pc_plus4, br_tgt, j_tgt;

  // A step-mode cycle without a pulse is indistinguishable from a stall,
  // and it also defers any redirect until the next pulse.
`ifdef IF_STEP_EN
  assign step_blk = StepMode & ~StepPulse;
`else
  assign step_blk = 1'b0;
`endif

  assign redirect = (BranchTaken | Jump) & ~step_blk;
  assign hold     = Stall | step_blk;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);
  assign br_tgt   = IdPCPlus4 + {{(PC_WIDTH-18){Instr[15]}}, Instr[15:0], 2'b00};
  assign j_tgt    = {IdPCPlus4[PC_WIDTH-1:28], Instr[25:0], 2'b00};

  always_comb begin
    pc_d  = pc_q;
    load  = 1'b0;
    flush = 1'b0;
    if (state_q == ST_RUN) begin
      if (redirect) begin
        // Redirect moves the PC even under Stall; the wrong-path fetch
        // becomes the single bubble.
        pc_d  = Jump ? j_tgt : br_tgt;
        flush = 1'b1;
      end else if (Halt) begin
        flush = 1'b1;
      end else if (!hold) begin
        pc_d = pc_plus4;
        load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        ST_RUN: begin
          if (!redirect && Halt) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(.PC_WIDTH(PC_WIDTH)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .flush_i (flush),
    .instr_i (ImemData),
    .pcp4_i  (pc_plus4),
    .instr_o (Instr),
    .pcp4_o  (IdPCPlus4),
    .valid_o (Valid)
  );

  assign ImemAddr = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign PC       = pc_q;
  assign Halted   = halted_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Stall = 1'b0, BranchTaken = 1'b0, Jump = 1'b0, Halt = 1'b0;
  logic        StepMode = 1'b0, StepPulse = 1'b0;
  logic [9:0]  ImemAddr;
  logic [31:0] ImemData;
  logic [31:0] PC, Instr, IdPCPlus4;
  logic        Valid, Halted;

  logic [31:0] imem [0:1023];
  assign ImemData = imem[ImemAddr];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .BranchTaken(BranchTaken),
    .Jump(Jump), .Halt(Halt),
`ifdef IF_STEP_EN
    .StepMode(StepMode), .StepPulse(StepPulse),
`endif
    .ImemAddr(ImemAddr), .ImemData(ImemData), .PC(PC), .Instr(Instr),
    .IdPCPlus4(IdPCPlus4), .Valid(Valid), .Halted(Halted)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural view of the stage.
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", PC, m_pc);
    chk("instr", Instr, m_instr);
    chk("pcp4", IdPCPlus4, m_pcp4);
    chk("valid", {31'b0, Valid}, {31'b0, m_valid});
    chk("halted", {31'b0, Halted}, {31'b0, m_halted});
    chk("imem_addr", {22'b0, ImemAddr}, {22'b0, m_pc[11:2]});
  endtask

  // One clock: derive the model's next state from the current inputs,
  // clock the DUT, then compare everything.
  task automatic cycle();
    logic [31:0] n_pc, n_instr, n_pcp4, btgt, jtgt;
    logic        n_valid, n_halted, blocked;
    blocked  = StepMode && !StepPulse;
`ifndef IF_STEP_EN
    blocked  = 1'b0;
`endif
    n_pc = m_pc; n_instr = m_instr; n_pcp4 = m_pcp4;
    n_valid = m_valid; n_halted = m_halted;
    btgt = m_pcp4 + 32'($signed(m_instr[15:0]) * 4);
    jtgt = (m_pcp4 & 32'hF000_0000) | ({6'b0, m_instr[25:0]} * 4);
    if (reset) begin
      n_pc = 32'h0; n_instr = 32'h0; n_pcp4 = 32'h0; n_valid = 0; n_halted = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if ((BranchTaken || Jump) && !blocked) begin
      n_pc = Jump ? jtgt : btgt; n_instr = 32'h0; n_valid = 0;
    end else if (Halt) begin
      n_halted = 1; n_instr = 32'h0; n_valid = 0;
    end else if (Stall || blocked) begin
      // hold
    end else begin
      n_instr = imem[m_pc[11:2]]; n_pcp4 = m_pc + 4; n_valid = 1; n_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pcp4 = n_pcp4;
    m_valid = n_valid; m_halted = n_halted;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_until_pc(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && m_pc != target; i++) cycle();
    checks++;
    if (m_pc != target) begin
      errors++;
      $display("FAIL run_until_pc: observed %h required %h", m_pc, target);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    imem[0] = 32'h2001_0001;
    imem[1] = 32'h2002_0002;
    imem[2] = 32'h2003_0003;
    imem[4] = 32'h1000_FFFF;  // BEQ at 0x10, offset -1 -> target 0x10
    imem[8] = 32'h0800_0040;  // J at 0x20 -> target 0x100
    m_pc = 32'hx; m_instr = 32'hx; m_pcp4 = 32'hx; m_valid = 1'bx; m_halted = 1'bx;

    // Reset and free run
    reset = 1'b1;
    @(posedge clk); #1;
    do_reset();
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", {31'b0, Valid}, 32'h0);
    chk("rst_halted", {31'b0, Halted}, 32'h0);
    cycle();
    chk("run_pc4", PC, 32'h4);
    chk("run_instr0", Instr, 32'h2001_0001);
    chk("run_pcp4_4", IdPCPlus4, 32'h4);
    chk("run_valid", {31'b0, Valid}, 32'h1);
    cycle();
    chk("run_pc8", PC, 32'h8);
    chk("run_instr1", Instr, 32'h2002_0002);

    // Stall three cycles at PC=8
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", PC, 32'h8);
      chk("stall_instr", Instr, 32'h2002_0002);
    end
    Stall = 1'b0;
    cycle();
    chk("resume_pc", PC, 32'hC);
    chk("resume_instr", Instr, 32'h2003_0003);

    // Taken branch, then again with Stall in the same cycle
    for (int rep = 0; rep < 2; rep++) begin
      run_until_pc(32'h14, 20);
      chk("beq_in_ifid", Instr, 32'h1000_FFFF);
      BranchTaken = 1'b1; Stall = (rep == 1);
      cycle();
      BranchTaken = 1'b0; Stall = 1'b0;
      chk("br_pc", PC, 32'h10);
      chk("br_bubble", Instr, 32'h0);
      chk("br_bubble_v", {31'b0, Valid}, 32'h0);
      cycle();
      chk("br_refetch", Instr, 32'h1000_FFFF);
    end

    // Jump, then Jump with BranchTaken
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 1) do_reset();
      run_until_pc(32'h24, 20);
      chk("j_pcp4", IdPCPlus4, 32'h24);
      chk("j_in_ifid", Instr, 32'h0800_0040);
      Jump = 1'b1; BranchTaken = (rep == 1);
      cycle();
      Jump = 1'b0; BranchTaken = 1'b0;
      chk("j_pc", PC, 32'h100);
      chk("j_bubble_v", {31'b0, Valid}, 32'h0);
    end

    // Halt at 0x30, stays halted through Stall toggling
    do_reset();
    run_until_pc(32'h30, 20);
    Halt = 1'b1;
    cycle();
    Halt = 1'b0;
    chk("halt_flag", {31'b0, Halted}, 32'h1);
    chk("halt_pc", PC, 32'h30);
    for (int i = 0; i < 20; i++) begin
      Stall = i[0];
      Halt = $urandom_range(0, 1);
      cycle();
      chk("halted_pc", PC, 32'h30);
      chk("halted_valid", {31'b0, Valid}, 32'h0);
    end
    Stall = 1'b0; Halt = 1'b0;
    do_reset();
    chk("unhalt_pc", PC, 32'h0);
    chk("unhalt_flag", {31'b0, Halted}, 32'h0);

`ifdef IF_STEP_EN
    // Single-step: three pulses in ten cycles -> 0 -> 4 -> 8 -> C
    do_reset();
    StepMode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      StepPulse = (i == 1 || i == 4 || i == 7);
      cycle();
    end
    StepPulse = 1'b0;
    chk("step_pc", PC, 32'hC);
    StepMode = 1'b0;
    cycle();
    cycle();
    chk("step_free_pc", PC, 32'h14);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 99) < 2);
      Stall       = ($urandom_range(0, 99) < 30);
      BranchTaken = ($urandom_range(0, 99) < 10);
      Jump        = ($urandom_range(0, 99) < 5);
      Halt        = !BranchTaken && !Jump && ($urandom_range(0, 99) < 3);
`ifdef IF_STEP_EN
      StepMode    = ($urandom_range(0, 99) < 30);
      StepPulse   = $urandom_range(0, 1);
`endif
      cycle();
    end
    reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; Halt = 1'b0;
    StepMode = 1'b0; StepPulse = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
